// File: rtl/hci_core_rr_arbiter.sv
// Round-robin N:1 arbiter with lock-until-grant and an in-order response-routing FIFO (stall counter under HCI_CORE_RR_ARBITER_STALL_CNT_EN).
// Latency: request and response paths are combinational (0 cycles); arbitration state updates on clk_i.
// Backpressure: out_req_o is withheld while the routing FIFO is full, unless a response pops it in the same cycle.
module hci_core_rr_arbiter #(
   parameter int unsigned NB_REQ          = 2,
   parameter int unsigned DW              = 32,
   parameter int unsigned AW              = 32,
   parameter int unsigned UW              = 2,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                             clk_i,
   input  logic                             clear_i,
   input  logic [NB_REQ-1:0]                in_req_i,
   output logic [NB_REQ-1:0]                in_gnt_o,
   input  logic [NB_REQ-1:0][AW-1:0]        in_add_i,
   input  logic [NB_REQ-1:0]                in_wen_i,
   input  logic [NB_REQ-1:0][DW/8-1:0]      in_be_i,
   input  logic [NB_REQ-1:0][DW-1:0]        in_data_i,
   input  logic [NB_REQ-1:0][UW-1:0]        in_user_i,
   output logic [NB_REQ-1:0]                in_r_valid_o,
   output logic [DW-1:0]                    in_r_data_o,
   output logic [UW-1:0]                    in_r_user_o,
   output logic                             out_req_o,
   input  logic                             out_gnt_i,
   output logic [AW-1:0]                    out_add_o,
   output logic                             out_wen_o,
   output logic [DW/8-1:0]                  out_be_o,
   output logic [DW-1:0]                    out_data_o,
   output logic [UW-1:0]                    out_user_o,
   input  logic                             out_r_valid_i,
   input  logic [DW-1:0]                    out_r_data_i,
   input  logic [UW-1:0]                    out_r_user_i,
   output logic [31:0]                      stall_cnt_o,
   output logic                             err_o
);

   localparam int unsigned IW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
   localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CW = PW + 1;

   typedef enum logic {
      ARB,
      LOCK
   } state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]   lock_idx_q, lock_idx_d;
   logic            err_q, err_d;

   logic [IW-1:0]   win_idx;
   logic            win_vld;
   logic [IW-1:0]   cand_idx;
   int unsigned     cand;

   logic [IW-1:0]   fifo_q [MAX_OUTSTANDING];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   cnt_q;
   logic            fifo_empty, fifo_full;
   logic            push, pop, drop, accept, hs;
   logic [IW-1:0]   head_idx;

   // Descending search so the candidate closest to rr_ptr is assigned last and wins.
   always_comb begin
      win_idx  = '0;
      win_vld  = 1'b0;
      cand     = 0;
      cand_idx = '0;
      if (state_q == LOCK) begin
         win_idx = lock_idx_q;
         win_vld = in_req_i[lock_idx_q];
      end else begin
         for (int k = int'(NB_REQ) - 1; k >= 0; k--) begin
            cand     = (int'(rr_ptr_q) + k) % NB_REQ;
            cand_idx = IW'(cand);
            if (in_req_i[cand_idx]) begin
               win_idx = cand_idx;
               win_vld = 1'b1;
            end
         end
      end
   end

   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == CW'(MAX_OUTSTANDING));
   assign pop        = out_r_valid_i & ~fifo_empty;
   assign drop       = out_r_valid_i & fifo_empty;
   assign accept     = ~fifo_full | pop;
   assign out_req_o  = win_vld & accept;
   assign hs         = out_req_o & out_gnt_i;
   assign push       = hs;
   assign head_idx   = fifo_q[rd_ptr_q];

   assign out_add_o  = in_add_i[win_idx];
   assign out_wen_o  = in_wen_i[win_idx];
   assign out_be_o   = in_be_i[win_idx];
   assign out_data_o = in_data_i[win_idx];
   assign out_user_o = in_user_i[win_idx];

   assign in_r_data_o = out_r_data_i;
   assign in_r_user_o = out_r_user_i;
   assign err_o       = err_q;

   always_comb begin
      in_gnt_o = '0;
      if (hs && !clear_i) begin
         in_gnt_o[win_idx] = 1'b1;
      end
   end

   always_comb begin
      in_r_valid_o = '0;
      if (pop && !clear_i) begin
         in_r_valid_o[head_idx] = 1'b1;
      end
   end

   // A dropped lock requester or a response with nothing outstanding are both protocol errors.
   always_comb begin
      state_d    = state_q;
      lock_idx_d = lock_idx_q;
      rr_ptr_d   = rr_ptr_q;
      err_d      = err_q | drop;
      unique case (state_q)
         ARB: begin
            if (out_req_o && !out_gnt_i) begin
               state_d    = LOCK;
               lock_idx_d = win_idx;
            end
         end
         LOCK: begin
            if (!in_req_i[lock_idx_q]) begin
               state_d = ARB;
               err_d   = 1'b1;
            end else if (out_gnt_i) begin
               state_d = ARB;
            end
         end
         default: state_d = ARB;
      endcase
      if (hs) begin
         rr_ptr_d = (win_idx == IW'(NB_REQ - 1)) ? '0 : win_idx + IW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         state_q    <= ARB;
         lock_idx_q <= '0;
         rr_ptr_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         lock_idx_q <= lock_idx_d;
         rr_ptr_q   <= rr_ptr_d;
         err_q      <= err_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         unique case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Index storage needs no reset: occupancy alone decides which entries are live.
   always_ff @(posedge clk_i) begin
      if (push && !clear_i) begin
         fifo_q[wr_ptr_q] <= win_idx;
      end
   end

`ifdef HCI_CORE_RR_ARBITER_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         stall_cnt_q <= '0;
      end else if (out_req_o && !out_gnt_i && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`else
   assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hci_core_rr_arbiter.sv
// Bench for hci_core_rr_arbiter: vector table, directed corner sequences, random traffic against a queue-based model.
module tb_hci_core_rr_arbiter;

   localparam int NB   = 2;
   localparam int DW   = 32;
   localparam int AW   = 32;
   localparam int UW   = 2;
   localparam int MAXO = 4;

   logic                     clk = 1'b0;
   logic                     clear;
   logic [NB-1:0]            in_req, in_gnt, in_wen, in_rv;
   logic [NB-1:0][AW-1:0]    in_add;
   logic [NB-1:0][DW/8-1:0]  in_be;
   logic [NB-1:0][DW-1:0]    in_data;
   logic [NB-1:0][UW-1:0]    in_user;
   logic [DW-1:0]            in_r_data;
   logic [UW-1:0]            in_r_user;
   logic                     out_req, out_gnt, out_wen, out_rv;
   logic [AW-1:0]            out_add;
   logic [DW/8-1:0]          out_be;
   logic [DW-1:0]            out_data, out_r_data;
   logic [UW-1:0]            out_user, out_r_user;
   logic [31:0]              stall;
   logic                     err;

   always #5 clk = ~clk;

   hci_core_rr_arbiter #(
      .NB_REQ(NB), .DW(DW), .AW(AW), .UW(UW), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk_i(clk), .clear_i(clear),
      .in_req_i(in_req), .in_gnt_o(in_gnt),
      .in_add_i(in_add), .in_wen_i(in_wen), .in_be_i(in_be),
      .in_data_i(in_data), .in_user_i(in_user),
      .in_r_valid_o(in_rv), .in_r_data_o(in_r_data), .in_r_user_o(in_r_user),
      .out_req_o(out_req), .out_gnt_i(out_gnt),
      .out_add_o(out_add), .out_wen_o(out_wen), .out_be_o(out_be),
      .out_data_o(out_data), .out_user_o(out_user),
      .out_r_valid_i(out_rv), .out_r_data_i(out_r_data), .out_r_user_i(out_r_user),
      .stall_cnt_o(stall), .err_o(err)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: requests served round-robin from a pointer, a locked
   // requester held until granted, outstanding owners kept in a queue.
   int          rr;
   bit          locked;
   int          lidx;
   int          q[$];
   bit          m_err;
   logic [31:0] m_stall;
   bit          model_ok = 1'b0;
   bit          m_vld, m_oreq;
   int          m_w;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_eval();
      m_vld = 1'b0;
      m_w   = 0;
      if (locked) begin
         m_w   = lidx;
         m_vld = in_req[lidx];
      end else begin
         for (int k = 0; k < NB; k++) begin
            int c;
            c = (rr + k) % NB;
            if (!m_vld && in_req[c]) begin
               m_w   = c;
               m_vld = 1'b1;
            end
         end
      end
      m_oreq = m_vld && (q.size() < MAXO || (out_rv && q.size() > 0));
   endtask

   task automatic model_check();
      logic [NB-1:0] eg, erv;
      eg  = '0;
      erv = '0;
      if (!clear && m_oreq && out_gnt) eg = NB'(1 << m_w);
      if (!clear && out_rv && q.size() > 0) erv = NB'(1 << q[0]);
      chk("m_out_req", 32'(out_req), 32'(m_oreq));
      chk("m_in_gnt", 32'(in_gnt), 32'(eg));
      chk("m_in_r_valid", 32'(in_rv), 32'(erv));
      chk("m_err", 32'(err), 32'(m_err));
`ifdef HCI_CORE_RR_ARBITER_STALL_CNT_EN
      chk("m_stall", stall, m_stall);
`else
      chk("m_stall", stall, 32'd0);
`endif
      if (m_oreq) begin
         chk("m_out_add", out_add, in_add[m_w]);
         chk("m_out_data", out_data, in_data[m_w]);
         chk("m_out_wen", 32'(out_wen), 32'(in_wen[m_w]));
      end
      if (erv != '0) chk("m_r_data", in_r_data, out_r_data);
   endtask

   task automatic model_update();
      if (clear) begin
         rr = 0; locked = 1'b0; lidx = 0; q.delete(); m_err = 1'b0; m_stall = '0;
         model_ok = 1'b1;
      end else begin
         if (out_rv) begin
            if (q.size() > 0) void'(q.pop_front());
            else m_err = 1'b1;
         end
         if (m_oreq && out_gnt) begin
            q.push_back(m_w);
            rr = (m_w + 1) % NB;
         end
         if (!locked) begin
            if (m_oreq && !out_gnt) begin
               locked = 1'b1;
               lidx   = m_w;
            end
         end else if (!in_req[lidx]) begin
            locked = 1'b0;
            m_err  = 1'b1;
         end else if (out_gnt) begin
            locked = 1'b0;
         end
         if (m_oreq && !out_gnt && m_stall != '1) m_stall = m_stall + 32'd1;
      end
   endtask

   task automatic set_in(input logic [NB-1:0] req, input logic gnt, input logic rv, input logic clr);
      in_req  = req;
      out_gnt = gnt;
      out_rv  = rv;
      clear   = clr;
      for (int i = 0; i < NB; i++) begin
         in_add[i]  = 32'hA000_0000 + 32'(i);
         in_data[i] = 32'hD000_0000 + 32'(i);
         in_wen[i]  = 1'(i);
         in_be[i]   = '1;
         in_user[i] = UW'(i);
      end
   endtask

   task automatic settle();
      #2;
      model_eval();
   endtask

   task automatic adv();
      if (model_ok) model_check();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic step();
      settle();
      adv();
   endtask

   typedef struct {
      logic [NB-1:0] req;
      logic          gnt;
      logic          rv;
      logic [NB-1:0] e_gnt;
      logic          e_oreq;
      logic [NB-1:0] e_rv;
      int            e_w;
   } vec_t;

   vec_t tbl[12];
   logic [DW-1:0] rdat[3];
   logic [NB-1:0] rexp[3];

   initial begin
      // Alternating grants with both requesting, then lock-until-grant on req0.
      tbl[0]  = '{2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 2'b00, 0};
      tbl[1]  = '{2'b11, 1'b1, 1'b1, 2'b10, 1'b1, 2'b01, 1};
      tbl[2]  = '{2'b11, 1'b1, 1'b1, 2'b01, 1'b1, 2'b10, 0};
      tbl[3]  = '{2'b11, 1'b1, 1'b1, 2'b10, 1'b1, 2'b01, 1};
      tbl[4]  = '{2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 2'b10, 0};
      tbl[5]  = '{2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 0};
      tbl[6]  = '{2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 0};
      tbl[7]  = '{2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 0};
      tbl[8]  = '{2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 2'b00, 0};
      tbl[9]  = '{2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 2'b00, 1};
      tbl[10] = '{2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 2'b01, 0};
      tbl[11] = '{2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 2'b10, 0};

      out_r_data = '0;
      out_r_user = '0;
      m_stall    = '0;
      set_in(2'b00, 1'b0, 1'b0, 1'b1);
      step();
      step();

      // Reset state
      set_in(2'b00, 1'b0, 1'b0, 1'b0);
      settle();
      chk("rst_out_req", 32'(out_req), 32'd0);
      chk("rst_in_gnt", 32'(in_gnt), 32'd0);
      chk("rst_in_r_valid", 32'(in_rv), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_stall", stall, 32'd0);
      adv();

      for (int i = 0; i < 12; i++) begin
         set_in(tbl[i].req, tbl[i].gnt, tbl[i].rv, 1'b0);
         out_r_data = 32'hC0DE_0000 + 32'(i);
         settle();
         chk("tbl_out_req", 32'(out_req), 32'(tbl[i].e_oreq));
         chk("tbl_in_gnt", 32'(in_gnt), 32'(tbl[i].e_gnt));
         chk("tbl_in_r_valid", 32'(in_rv), 32'(tbl[i].e_rv));
         if (tbl[i].e_oreq) chk("tbl_out_add", out_add, 32'hA000_0000 + 32'(tbl[i].e_w));
         adv();
      end

      // FIFO full: four grants, request withheld, then released by a same-cycle pop.
      set_in(2'b00, 1'b0, 1'b0, 1'b1);
      step();
      for (int i = 0; i < 4; i++) begin
         set_in(2'b11, 1'b1, 1'b0, 1'b0);
         settle();
         chk("full_fill_gnt", 32'(in_gnt), (i % 2 == 0) ? 32'd1 : 32'd2);
         adv();
      end
      set_in(2'b11, 1'b1, 1'b0, 1'b0);
      settle();
      chk("full_out_req", 32'(out_req), 32'd0);
      chk("full_in_gnt", 32'(in_gnt), 32'd0);
      adv();
      set_in(2'b11, 1'b1, 1'b1, 1'b0);
      out_r_data = 32'h5555_AAAA;
      settle();
      chk("full_pop_out_req", 32'(out_req), 32'd1);
      chk("full_pop_in_gnt", 32'(in_gnt), 32'd1);
      chk("full_pop_r_valid", 32'(in_rv), 32'd1);
      adv();
      for (int i = 0; i < 4; i++) begin
         set_in(2'b00, 1'b0, 1'b1, 1'b0);
         settle();
         chk("full_drain_r_valid", 32'(in_rv), (i % 2 == 0) ? 32'd2 : 32'd1);
         adv();
      end

      // Grants 1,0,1 then three in-order responses.
      set_in(2'b10, 1'b1, 1'b0, 1'b0); step();
      set_in(2'b01, 1'b1, 1'b0, 1'b0); step();
      set_in(2'b10, 1'b1, 1'b0, 1'b0); step();
      rdat[0] = 32'h1111_0001; rdat[1] = 32'h2222_0002; rdat[2] = 32'h3333_0003;
      rexp[0] = 2'b10; rexp[1] = 2'b01; rexp[2] = 2'b10;
      for (int i = 0; i < 3; i++) begin
         set_in(2'b00, 1'b0, 1'b1, 1'b0);
         out_r_data = rdat[i];
         settle();
         chk("order_r_valid", 32'(in_rv), 32'(rexp[i]));
         chk("order_r_data", in_r_data, rdat[i]);
         adv();
      end

      // Response with nothing outstanding, then sticky error until clear.
      set_in(2'b00, 1'b0, 1'b1, 1'b0);
      settle();
      chk("empty_r_valid", 32'(in_rv), 32'd0);
      adv();
      for (int i = 0; i < 2; i++) begin
         set_in(2'b00, 1'b0, 1'b0, 1'b0);
         settle();
         chk("err_sticky", 32'(err), 32'd1);
         adv();
      end
      set_in(2'b00, 1'b0, 1'b0, 1'b1); step();
      set_in(2'b00, 1'b0, 1'b0, 1'b0);
      settle();
      chk("err_cleared", 32'(err), 32'd0);
      adv();

      // Five stalled cycles on req0.
      for (int i = 0; i < 5; i++) begin
         set_in(2'b01, 1'b0, 1'b0, 1'b0);
         step();
      end
      set_in(2'b01, 1'b1, 1'b0, 1'b0);
      settle();
`ifdef HCI_CORE_RR_ARBITER_STALL_CNT_EN
      chk("stall_five", stall, 32'd5);
`else
      chk("stall_tied", stall, 32'd0);
`endif
      chk("stall_grant", 32'(in_gnt), 32'd1);
      adv();
      set_in(2'b00, 1'b0, 1'b1, 1'b0);
      settle();
      chk("stall_resp", 32'(in_rv), 32'd1);
      adv();

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         in_req  = NB'($urandom);
         out_gnt = 1'($urandom_range(0, 1));
         out_rv  = (q.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
         clear   = ($urandom_range(0, 49) == 0);
         out_r_data = $urandom;
         out_r_user = UW'($urandom);
         for (int i = 0; i < NB; i++) begin
            in_add[i]  = $urandom;
            in_data[i] = $urandom;
            in_wen[i]  = 1'($urandom);
            in_be[i]   = 4'($urandom);
            in_user[i] = UW'($urandom);
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
